// File: rtl/sysid_checker.sv
// sysid_checker
//   Avalon-MM read master that fetches the system-ID word (BASE_ADDR+0) and
//   the build timestamp word (BASE_ADDR+4), compares both against build-time
//   constants and reports the outcome. Used to gate boot when the software
//   image and the FPGA image disagree.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   start               one-cycle request to run a check (ignored while busy)
//   busy                high from the cycle after start until done
//   done                one-cycle pulse when a check finishes
//   pass                id_ok & ts_ok & !timeout, held until the next start
//   id_ok, ts_ok        per-word match flags, held until the next start
//   timeout             a read phase ran out of cycles, held until next start
//   id_value, ts_value  last captured ID / timestamp words
//   avm_*               Avalon-MM read master (single outstanding read)
module sysid_checker #(
  parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1326988104,
  parameter bit          USE_READDATAVALID  = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID_REQ  = 3'd1,
    ID_WAIT = 3'd2,
    TS_REQ  = 3'd3,
    TS_WAIT = 3'd4,
    FIN     = 3'd5
  } state_t;

  localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_CYCLES);
  localparam logic [31:0] TS_ADDR   = BASE_ADDR + 32'd4;

  state_t      state, state_n;
  logic [15:0] tmo_cnt;
  logic        accept;
  logic        tmo_hit;
  logic        in_phase;
  logic        cap_id, cap_ts, abort;
  logic        id_hit, ts_hit;

  assign accept   = avm_read && !avm_waitrequest;
  assign in_phase = (state == ID_REQ) || (state == ID_WAIT) ||
                    (state == TS_REQ) || (state == TS_WAIT);
  // The current cycle is the last one allowed for this phase.
  assign tmo_hit  = ({1'b0, tmo_cnt} + 17'd1) == TMO_LIMIT;

  // The ID word is only valid once the bus has moved on to the timestamp
  // phase; the timestamp word is judged from the data arriving this cycle so
  // that the flags appear together with the done pulse.
  assign id_hit = ((state == TS_REQ) || (state == TS_WAIT)) &&
                  (id_value == EXPECTED_ID);
  assign ts_hit = cap_ts && (avm_readdata == EXPECTED_TIMESTAMP);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // A completed transfer always wins over the timeout in the same cycle.
  always_comb begin
    state_n = state;
    cap_id  = 1'b0;
    cap_ts  = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = ID_REQ;
      ID_REQ: begin
        if (accept) begin
          if (USE_READDATAVALID) begin
            state_n = ID_WAIT;
          end else begin
            cap_id  = 1'b1;
            state_n = TS_REQ;
          end
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_n = FIN;
        end
      end
      ID_WAIT: begin
        if (avm_readdatavalid) begin
          cap_id  = 1'b1;
          state_n = TS_REQ;
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_n = FIN;
        end
      end
      TS_REQ: begin
        if (accept) begin
          if (USE_READDATAVALID) begin
            state_n = TS_WAIT;
          end else begin
            cap_ts  = 1'b1;
            state_n = FIN;
          end
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_n = FIN;
        end
      end
      TS_WAIT: begin
        if (avm_readdatavalid) begin
          cap_ts  = 1'b1;
          state_n = FIN;
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_n = FIN;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // All outputs are registered from the next-state decision so the bus
  // request, address and result flags change on the same edge as the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      avm_address <= '0;
      avm_read    <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      done     <= 1'b0;
      avm_read <= (state_n == ID_REQ) || (state_n == TS_REQ);

      if (state_n == ID_REQ)      avm_address <= BASE_ADDR;
      else if (state_n == TS_REQ) avm_address <= TS_ADDR;

      if ((state_n != state) || !in_phase) tmo_cnt <= '0;
      else                                 tmo_cnt <= tmo_cnt + 16'd1;

      if (cap_id) id_value <= avm_readdata;
      if (cap_ts) ts_value <= avm_readdata;

      if ((state == IDLE) && start) begin
        busy    <= 1'b1;
        pass    <= 1'b0;
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
        timeout <= 1'b0;
      end

      if (state_n == FIN) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        id_ok   <= id_hit;
        ts_ok   <= ts_hit;
        timeout <= abort;
        pass    <= id_hit && ts_hit && !abort;
      end
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker
//   Two instances share one behavioural Avalon slave: index 0 samples data in
//   the accept cycle, index 1 waits for readdatavalid. Only the selected
//   instance is ever started, so the idle one just sees ignored bus traffic.
module tb_sysid_checker;

  localparam logic [31:0] BASE   = 32'h0001_0040;
  localparam logic [31:0] EXP_ID = 32'hC0DE_0042;
  localparam logic [31:0] EXP_TS = 32'd1326988104;
  localparam int          TMO    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start   [2];
  logic        busy    [2];
  logic        done    [2];
  logic        pass    [2];
  logic        id_ok   [2];
  logic        ts_ok   [2];
  logic        timeout [2];
  logic        rd      [2];
  logic [31:0] id_val  [2];
  logic [31:0] ts_val  [2];
  logic [31:0] addr    [2];

  logic        waitreq, rdv;
  logic [31:0] rdata;
  bit          sel = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sysid_checker #(
    .BASE_ADDR(BASE), .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .USE_READDATAVALID(1'b0), .TIMEOUT_CYCLES(TMO)
  ) u_dut0 (
    .clock(clk), .reset(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]), .timeout(timeout[0]),
    .id_value(id_val[0]), .ts_value(ts_val[0]), .avm_address(addr[0]),
    .avm_read(rd[0]), .avm_waitrequest(waitreq), .avm_readdata(rdata),
    .avm_readdatavalid(rdv)
  );

  sysid_checker #(
    .BASE_ADDR(BASE), .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .USE_READDATAVALID(1'b1), .TIMEOUT_CYCLES(TMO)
  ) u_dut1 (
    .clock(clk), .reset(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]), .timeout(timeout[1]),
    .id_value(id_val[1]), .ts_value(ts_val[1]), .avm_address(addr[1]),
    .avm_read(rd[1]), .avm_waitrequest(waitreq), .avm_readdata(rdata),
    .avm_readdatavalid(rdv)
  );

  // Behavioural slave: stalls each request for a configured number of
  // cycles, answers in the accept cycle (index 0) or lat cycles later
  // (index 1), and drives random junk on readdata otherwise.
  logic [31:0] id_word = '0, ts_word = '0, junk = '0, vword = '0;
  int          wait_id = 0, wait_ts = 0, lat = 1, stall = 0, vcnt = 0;
  logic        vpend = 1'b0, stray = 1'b0;
  logic        m_read, accept;
  logic [31:0] m_addr;
  int          id_rd_cyc = 0, ts_rd_cyc = 0, glitches = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  assign m_read  = rd[sel];
  assign m_addr  = addr[sel];
  assign waitreq = m_read && (stall < ((m_addr == BASE) ? wait_id : wait_ts));
  assign accept  = m_read && !waitreq;

  always_comb begin
    rdv   = stray || (vpend && vcnt == 0);
    rdata = junk;
    if (vpend && vcnt == 0)     rdata = vword;
    else if (!sel && accept)    rdata = (m_addr == BASE) ? id_word : ts_word;
  end

  always @(posedge clk) begin
    junk  <= $urandom;
    stall <= (m_read && waitreq) ? stall + 1 : 0;
    if (sel && accept) begin
      vpend <= 1'b1;
      vcnt  <= lat - 1;
      vword <= (m_addr == BASE) ? id_word : ts_word;
    end else if (vpend) begin
      if (vcnt == 0) vpend <= 1'b0;
      else           vcnt  <= vcnt - 1;
    end
    if (m_read && m_addr == BASE)         id_rd_cyc <= id_rd_cyc + 1;
    if (m_read && m_addr == BASE + 32'd4) ts_rd_cyc <= ts_rd_cyc + 1;
    if (m_read && prev_stall && m_addr != prev_addr) glitches <= glitches + 1;
    prev_stall <= m_read && waitreq;
    prev_addr  <= m_addr;
  end

  // Last word each instance should be holding.
  logic [31:0] m_id [2];
  logic [31:0] m_ts [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Work out phase lengths from the slave settings, then run the check and
  // compare against them.
  task automatic run(input bit s, input logic [31:0] iw, input logic [31:0] tw,
                     input int wid, input int wts, input int lt, input bit poke);
    int n, exp_n, idrc, tsrc, id0, ts0, gl0;
    bit to, idc, tsc, e_idok, e_tsok, pass_was;
    to = 0; idc = 0; tsc = 0; exp_n = 1; idrc = 0; tsrc = 0;
    if (wid + 1 > TMO) begin
      exp_n += TMO; idrc = TMO; to = 1;
    end else begin
      exp_n += wid + 1; idrc = wid + 1;
      if (s && lt > TMO) begin exp_n += TMO; to = 1; end
      else begin if (s) exp_n += lt; idc = 1; end
    end
    if (idc) begin
      if (wts + 1 > TMO) begin
        exp_n += TMO; tsrc = TMO; to = 1;
      end else begin
        exp_n += wts + 1; tsrc = wts + 1;
        if (s && lt > TMO) begin exp_n += TMO; to = 1; end
        else begin if (s) exp_n += lt; tsc = 1; end
      end
    end
    if (idc) m_id[s] = iw;
    if (tsc) m_ts[s] = tw;
    e_idok = idc && (iw == EXP_ID);
    e_tsok = tsc && (tw == EXP_TS);

    sel = s; id_word = iw; ts_word = tw; wait_id = wid; wait_ts = wts; lat = lt;
    id0 = id_rd_cyc; ts0 = ts_rd_cyc; gl0 = glitches;
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
    n = 1;
    check("busy_after_start", busy[s], 1);
    while (!done[s] && n < 200) begin
      if (poke && n == 1) start[s] = 1'b1;
      @(negedge clk);
      start[s] = 1'b0;
      n++;
    end
    if (!done[s]) begin
      check("done_seen", done[s], 1);
    end else begin
      check("done_latency", n, exp_n);
      check("busy_at_done", busy[s], 0);
      check("read_at_done", rd[s], 0);
      check("pass", pass[s], e_idok && e_tsok && !to);
      check("id_ok", id_ok[s], e_idok);
      check("ts_ok", ts_ok[s], e_tsok);
      check("timeout", timeout[s], to);
      check("id_value", id_val[s], m_id[s]);
      check("ts_value", ts_val[s], m_ts[s]);
      check("id_read_cycles", id_rd_cyc - id0, idrc);
      check("ts_read_cycles", ts_rd_cyc - ts0, tsrc);
      check("addr_stable", glitches - gl0, 0);
      pass_was = pass[s];
      if (poke) start[s] = 1'b1;
      @(negedge clk);
      start[s] = 1'b0;
      check("done_one_cycle", done[s], 0);
      check("idle_after_fin", busy[s], 0);
      check("pass_sticky", pass[s], pass_was);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cnt;
    start[0] = 1'b0; start[1] = 1'b0;
    m_id[0] = '0; m_id[1] = '0; m_ts[0] = '0; m_ts[1] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", busy[i], 0);
      check("rst_done", done[i], 0);
      check("rst_flags", {pass[i], id_ok[i], ts_ok[i], timeout[i]}, 0);
      check("rst_read", rd[i], 0);
      check("rst_addr", addr[i], 0);
      check("rst_values", id_val[i] | ts_val[i], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    run(0, EXP_ID, EXP_TS, 0, 0, 1, 0);          // zero-wait, pass
    run(0, EXP_ID, 32'h12345678, 0, 0, 1, 0);    // timestamp mismatch
    run(0, 32'h0000_0000, EXP_TS, 0, 0, 1, 1);   // ID mismatch, start pokes
    run(0, EXP_ID, EXP_TS, 5, 0, 1, 1);          // 5 stall cycles on ID
    run(0, EXP_ID, EXP_TS, 7, 7, 1, 0);          // accept on last allowed cycle
    // stray readdatavalid while idle must not disturb the RDV instance
    sel = 1'b1;
    stray = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    check("stray_busy", busy[1], 0);
    check("stray_id_value", id_val[1], m_id[1]);
    run(1, EXP_ID, EXP_TS, 0, 0, 3, 0);          // valid 3 cycles after accept
    run(1, EXP_ID, EXP_TS, 2, 1, 8, 1);          // valid on last allowed cycle
    run(0, EXP_ID, EXP_TS, 1000, 0, 1, 0);       // stuck waitrequest on ID
    run(0, EXP_ID, EXP_TS, 0, 1000, 1, 0);       // stuck on timestamp
    run(1, EXP_ID, EXP_TS, 0, 0, 20, 0);         // valid never in time

    // reset while the timestamp request is stalled
    sel = 1'b0; id_word = EXP_ID; ts_word = EXP_TS; wait_id = 0; wait_ts = 20;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    check("pre_rst_ts_req", rd[0] && (addr[0] == BASE + 32'd4), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_read", rd[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_done", done[0], 0);
    check("midrst_id_value", id_val[0], 0);
    m_id[0] = '0; m_id[1] = '0; m_ts[0] = '0; m_ts[1] = '0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done[0]) cnt++;
    end
    check("midrst_no_done", cnt, 0);
    run(0, EXP_ID, EXP_TS, 0, 0, 1, 0);

    for (int k = 0; k < 30; k++) begin
      bit          s;
      logic [31:0] iw, tw;
      s  = 1'($urandom_range(0, 1));
      iw = ($urandom_range(0, 3) != 0) ? EXP_ID : $urandom;
      tw = ($urandom_range(0, 3) != 0) ? EXP_TS : $urandom;
      run(s, iw, tw, $urandom_range(0, 9), $urandom_range(0, 9),
          $urandom_range(1, 9), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
